// File: rtl/mealy_frame_sched_pkg.sv
// Shared definitions for the Mealy frame scheduler: the state encoding,
// the default frame width and the helper that sizes the detection count.
package mealy_frame_sched_pkg;

  localparam int FRAME_W_DEF = 8;

  // The count must hold 0..frame_w inclusive, hence frame_w+1 values.
  function automatic int cnt_w(input int frame_w);
    return $clog2(frame_w + 1);
  endfunction

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SHIFT = 2'd2,
    RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/mealy_frame_sched_if.sv
// Request/response bus between the requesters and the frame scheduler.
// Handshake rule for both channels: a transfer happens on a rising edge where
// valid and ready are both 1; a source holding valid keeps its payload stable
// until that edge, and ready is never raised for a lane whose valid is 0.
interface mealy_frame_sched_if
  import mealy_frame_sched_pkg::*;
#(
  parameter int FRAME_W = FRAME_W_DEF,
  parameter int CNT_W   = cnt_w(FRAME_W)
) ();

  logic [1:0]         req_valid;
  logic [FRAME_W-1:0] req_data0;
  logic [FRAME_W-1:0] req_data1;
  logic [1:0]         req_ready;
  logic               rsp_valid;
  logic               rsp_ready;
  logic               rsp_id;
  logic [CNT_W-1:0]   rsp_count;

  // Requester/consumer side.
  modport master (
    output req_valid, req_data0, req_data1, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_count
  );

  // Scheduler side.
  modport slave (
    input  req_valid, req_data0, req_data1, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_count
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. ptr=1 means requester 1 has priority when both
// request; a lone requester always wins. The pointer moves only on update.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt,
  output logic       ptr
);

  logic ptr_q;
  logic ptr_d;

  // Grant selection and pointer advance toward the requester not just served.
  always_comb begin
    gnt   = 2'b00;
    ptr_d = ptr_q;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = ptr_q ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
    if (update && (gnt != 2'b00)) begin
      ptr_d = gnt[0];
    end
  end

  // Pointer register; reset favours requester 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/mealy_frame_sched.sv
// Frame scheduler: arbitrates two requesters, serializes the granted frame
// LSB-first into an external Mealy detector, counts det_z hits and returns
// the count on a response handshake. FRAME_W must match the bus instance.
module mealy_frame_sched
  import mealy_frame_sched_pkg::*;
#(
  parameter int FRAME_W = FRAME_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  mealy_frame_sched_if.slave        bus,
  output logic                      det_clr,
  output logic                      det_en,
  output logic                      det_x,
  input  logic                      det_z,
  output logic                      busy,
  output state_e                    state_dbg,
  output logic                      rr_ptr_dbg
);

  localparam int CNT_W = cnt_w(FRAME_W);
  localparam int IDX_W = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_W - 1);

  state_e             state_q, state_d;
  logic [FRAME_W-1:0] data_q, data_d;
  logic               id_q, id_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [1:0]         arb_req;
  logic [1:0]         gnt;
  logic               accept;
  logic               rr_ptr;

  logic [1:0]         req_ready;
  logic               rsp_valid;
  logic               rsp_id;
  logic [CNT_W-1:0]   rsp_count;

  // The arbiter only sees requests while IDLE and out of reset, so a grant
  // is always an accept and the pointer only moves on real transfers.
  assign arb_req = (state_q == IDLE && !rst) ? bus.req_valid : 2'b00;
  assign accept  = (gnt != 2'b00);

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (arb_req),
    .update (accept),
    .gnt    (gnt),
    .ptr    (rr_ptr)
  );

  // Next-state and Mealy outputs; everything is forced to 0 while rst is high.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    id_d      = id_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    req_ready = 2'b00;
    det_clr   = 1'b0;
    det_en    = 1'b0;
    det_x     = 1'b0;
    rsp_valid = 1'b0;
    rsp_id    = 1'b0;
    rsp_count = '0;
    busy      = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          req_ready = gnt;
          if (accept) begin
            data_d  = gnt[1] ? bus.req_data1 : bus.req_data0;
            id_d    = gnt[1];
            state_d = CLEAR;
          end
        end
        CLEAR: begin
          busy    = 1'b1;
          det_clr = 1'b1;
          idx_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
        SHIFT: begin
          busy   = 1'b1;
          det_en = 1'b1;
          det_x  = data_q[idx_q];
          if (det_z) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          if (idx_q == LAST_IDX) begin
            state_d = RESP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        RESP: begin
          busy      = 1'b1;
          rsp_valid = 1'b1;
          rsp_id    = id_q;
          rsp_count = cnt_q;
          if (bus.rsp_ready) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      id_q    <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      id_q    <= id_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_id    = rsp_id;
  assign bus.rsp_count = rsp_count;
  assign state_dbg     = state_q;
  assign rr_ptr_dbg    = rr_ptr;

endmodule

// File: tb/tb_mealy_frame_sched.sv
// Directed bench for mealy_frame_sched with a stand-in detector whose det_z
// follows a per-frame mask, and a scoreboard of expected {id, count}.
module tb_mealy_frame_sched;
  import mealy_frame_sched_pkg::*;

  localparam int FW = 8;
  localparam int CW = cnt_w(FW);

  logic   clk = 1'b0;
  logic   rst;
  logic   det_clr, det_en, det_x, det_z, busy, rr_ptr_dbg;
  state_e state_dbg;

  mealy_frame_sched_if #(.FRAME_W(FW)) bus ();

  mealy_frame_sched #(.FRAME_W(FW)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .det_clr    (det_clr),
    .det_en     (det_en),
    .det_x      (det_x),
    .det_z      (det_z),
    .busy       (busy),
    .state_dbg  (state_dbg),
    .rr_ptr_dbg (rr_ptr_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  // Detector stand-in: det_z = mask bit for the current SHIFT cycle while
  // det_en is high, otherwise z_idle (which the DUT must ignore).
  logic [15:0] z_mask;
  logic        z_idle;
  logic [4:0]  sh_idx;

  always @(posedge clk) begin
    if (det_clr) sh_idx <= 5'd0;
    else if (det_en) sh_idx <= sh_idx + 5'd1;
  end

  assign det_z = det_en ? z_mask[sh_idx[3:0]] : z_idle;

  // Scoreboard
  logic [CW:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({bus.req_ready, det_clr, det_en, det_x, bus.rsp_valid,
                bus.rsp_id, bus.rsp_count, busy});
  endfunction

  // One complete frame, starting just after an edge with requests already driven.
  task automatic run_frame(input int exp_id, input logic [FW-1:0] data,
                           input logic [15:0] mask, input int stall, input bit drop);
    logic [CW:0] e;
    z_mask = mask;
    #1;
    chk("grant", 32'(bus.req_ready), (exp_id != 0) ? 32'h2 : 32'h1);
    chk("idle_busy", 32'(busy), 32'h0);
    exp_q.push_back({exp_id[0], CW'($countones(mask[FW-1:0]))});
    tick();
    if (drop) bus.req_valid = 2'b00;
    #1;
    chk("clear", 32'({state_dbg, det_clr, det_en, busy, bus.req_ready}),
        32'({CLEAR, 1'b1, 1'b0, 1'b1, 2'b00}));
    for (int i = 0; i < FW; i++) begin
      tick();
      chk($sformatf("shift%0d", i),
          32'({det_en, det_clr, det_x, bus.req_ready, bus.rsp_valid}),
          32'({1'b1, 1'b0, data[i], 2'b00, 1'b0}));
    end
    tick();
    e = exp_q[0];
    for (int s = 0; s < stall; s++) begin
      chk($sformatf("stall%0d", s),
          32'({bus.rsp_valid, bus.rsp_id, bus.rsp_count, bus.req_ready, busy}),
          32'({1'b1, e, 2'b00, 1'b1}));
      tick();
    end
    bus.rsp_ready = 1'b1;
    #1;
    e = exp_q.pop_front();
    chk("rsp", 32'({bus.rsp_valid, bus.rsp_id, bus.rsp_count}), 32'({1'b1, e}));
    tick();
    bus.rsp_ready = 1'b0;
    chk("back_idle", 32'(state_dbg), 32'(IDLE));
  endtask

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  // Directed sequence
  initial begin
    bus.req_valid = 2'b00;
    bus.req_data0 = '0;
    bus.req_data1 = '0;
    bus.rsp_ready = 1'b0;
    z_mask        = '0;
    z_idle        = 1'b0;
    rst           = 1'b1;

    // Reset: outputs stay 0 even with a request pending.
    tick();
    bus.req_valid = 2'b01;
    #1;
    chk("rst_outs_during", all_outs(), 32'h0);
    tick();
    chk("rst_outs_during2", all_outs(), 32'h0);
    rst = 1'b0;
    bus.req_valid = 2'b00;
    #1;
    chk("rst_outs_after", all_outs(), 32'h0);
    chk("rst_state", 32'(state_dbg), 32'(IDLE));
    chk("rst_ptr", 32'(rr_ptr_dbg), 32'h0);

    // Single request, no detections.
    bus.req_data0 = 8'hA5;
    bus.req_valid = 2'b01;
    run_frame(0, 8'hA5, 16'h0000, 0, 1'b1);

    // Lone requester 0 wins although pointer favours 1; all detections,
    // det_z held high outside SHIFT must not be counted.
    z_idle = 1'b1;
    bus.req_data0 = 8'h3C;
    bus.req_valid = 2'b01;
    run_frame(0, 8'h3C, 16'h00FF, 0, 1'b1);

    // Requester 1, exactly three detections.
    bus.req_data1 = 8'h5A;
    bus.req_valid = 2'b10;
    run_frame(1, 8'h5A, 16'h004A, 0, 1'b1);

    // Contention held across back-to-back frames; middle one backpressured.
    bus.req_data0 = 8'h96;
    bus.req_data1 = 8'h69;
    bus.req_valid = 2'b11;
    run_frame(0, 8'h96, 16'h0081, 0, 1'b0);
    run_frame(1, 8'h69, 16'h00F0, 5, 1'b0);
    run_frame(0, 8'h96, 16'h0001, 0, 1'b1);

    // Reset during the 4th SHIFT cycle of a requester-0 frame.
    z_mask = 16'h00FF;
    bus.req_valid = 2'b01;
    #1;
    chk("int_grant", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = 2'b00;
    repeat (4) tick();
    chk("int_shift4", 32'({state_dbg, det_en}), 32'({SHIFT, 1'b1}));
    rst = 1'b1;
    #1;
    chk("int_rst_during", all_outs(), 32'h0);
    tick();
    rst = 1'b0;
    #1;
    chk("int_rst_after", all_outs(), 32'h0);
    chk("int_state", 32'(state_dbg), 32'(IDLE));
    chk("int_ptr", 32'(rr_ptr_dbg), 32'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("int_no_rsp%0d", k), 32'(bus.rsp_valid), 32'h0);
    end

    // After reset the pointer favours requester 0 under contention.
    bus.req_valid = 2'b11;
    run_frame(0, 8'h96, 16'h0024, 0, 1'b1);

    chk("exp_q_empty", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
